// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Multi-cycle multiply/divide unit for the EX stage. Owns the architectural
//   HI/LO registers. A MULT/MULTU/DIV/DIVU request computes its result into
//   shadow registers on the accepting edge, holds busy for MULT_CYCLES or
//   DIV_CYCLES cycles, then commits the shadow values to HI/LO. MTHI/MTLO
//   write HI/LO directly on the next edge without raising busy.
//
// Ports
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous, active-high reset
//   start  in   1   one-cycle request strobe
//   md_op  in   3   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 NONE
//   A      in   32  rs operand (forwarded)
//   B      in   32  rt operand (forwarded)
//   busy   out  1   high while a mult/div is in flight
//   HI     out  32  architectural HI register
//   LO     out  32  architectural LO register
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int unsigned MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CLOG  = $clog2(MAXC + 1);
    localparam int unsigned CW    = (CLOG > 4) ? CLOG : 4;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [31:0]   sh_hi_q, sh_hi_d;
    logic [31:0]   sh_lo_q, sh_lo_d;
    logic          sh_wr_q, sh_wr_d;
    logic [31:0]   hi_q,    hi_d;
    logic [31:0]   lo_q,    lo_d;

    // ------------------------------------------------------------------
    // Arithmetic datapath (evaluated on the accepting edge)
    // ------------------------------------------------------------------
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] dvs_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Lower 64 bits of the sign-extended 64x64 product equal the signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'b0, A} * {32'b0, B};

    // Signed divide is done on magnitudes and re-signed afterwards, which
    // gives truncation toward zero and makes 0x80000000 / -1 wrap cleanly
    // to 0x80000000 with remainder 0.
    assign div_signed = (md_op == OP_DIV);
    assign dvd_mag    = (div_signed && A[31]) ? (32'd0 - A) : A;
    assign dvs_mag    = (div_signed && B[31]) ? (32'd0 - B) : B;
    // Divide-by-zero results are never committed; keep the divider defined.
    assign dvs_safe   = (dvs_mag == '0) ? 32'd1 : dvs_mag;
    assign q_mag      = dvd_mag / dvs_safe;
    assign r_mag      = dvd_mag % dvs_safe;
    assign quot       = (div_signed && (A[31] ^ B[31])) ? (32'd0 - q_mag) : q_mag;
    assign rem        = (div_signed && A[31]) ? (32'd0 - r_mag) : r_mag;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        sh_wr_d = sh_wr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT: begin
                            sh_hi_d = prod_s[63:32];
                            sh_lo_d = prod_s[31:0];
                            sh_wr_d = 1'b1;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MULTU: begin
                            sh_hi_d = prod_u[63:32];
                            sh_lo_d = prod_u[31:0];
                            sh_wr_d = 1'b1;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            sh_hi_d = rem;
                            sh_lo_d = quot;
                            sh_wr_d = (B != '0);
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end

            S_RUN: begin
                // Requests arriving here are ignored by construction.
                if (cnt_q <= CW'(1)) begin
                    if (sh_wr_q) begin
                        hi_d = sh_hi_q;
                        lo_d = sh_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
            sh_wr_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
            sh_wr_q <= sh_wr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed bench for mult_div_unit. Expected HI/LO pairs come from a small
//   64-bit reference model and are queued when an op is issued, then popped
//   and compared when the unit finishes.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mult_div_unit #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .md_op(md_op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [63:0] sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {hi, lo} after the op given the current HI/LO.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] ch,
                                          input logic [31:0] cl);
        longint          sa, sb2, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     t;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        case (op)
            3'd1: begin t = sa * sb2; return t; end
            3'd2: begin t = ua * ub;  return t; end
            3'd3: begin
                if (b == 0) return {ch, cl};
                q = sa / sb2;
                r = sa % sb2;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 0) return {ch, cl};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            3'd5: return {a, cl};
            3'd6: return {ch, a};
            default: return {ch, cl};
        endcase
    endfunction

    // Called #1 after a posedge; returns #1 after the edge that samples the request.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(posedge clk); #1;
        start = 1'b0;
        md_op = 3'd0;
        A     = '0;
        B     = '0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        e = model(op, a, b, m_hi, m_lo);
        sb.push_back(e);
        start_op(op, a, b);
    endtask

    task automatic pop_check(input string tag);
        logic [63:0] e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed empty-queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk(tag, {HI, LO}, e);
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
    endtask

    // Counts busy cycles (starting from 'already'), checking HI/LO hold old values.
    task automatic wait_done(input string tag, input int n_exp, input int already);
        int cnt;
        cnt = already;
        while (busy === 1'b1 && cnt < 64) begin
            chk({tag, "_hold"}, {HI, LO}, {m_hi, m_lo});
            cnt++;
            @(posedge clk); #1;
        end
        chk({tag, "_busycyc"}, 64'(cnt), 64'(n_exp));
        chk({tag, "_busy0"}, {63'b0, busy}, 64'd0);
        pop_check(tag);
    endtask

    task automatic run_md(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        wait_done(tag, (op <= 3'd2) ? int'(MC) : int'(DC), 0);
    endtask

    task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
        issue(op, a, 32'h0);
        chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
        pop_check(tag);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hilo", {HI, LO}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_md("mult_neg", 3'd1, 32'hFFFFFFFE, 32'd3);
        chk("mult_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
        run_md("multu", 3'd2, 32'hFFFFFFFE, 32'd3);
        chk("multu_const", {HI, LO}, 64'h00000002_FFFFFFFA);
        run_md("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2);
        chk("div_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        run_md("divu", 3'd4, 32'd7, 32'd2);
        chk("divu_const", {HI, LO}, 64'h00000001_00000003);
        run_md("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_const", {HI, LO}, 64'h00000000_80000000);

        run_mt("mthi5", 3'd5, 32'd5);
        run_mt("mtlo6", 3'd6, 32'd6);
        run_md("divu_zero", 3'd4, 32'd99, 32'd0);
        chk("divz_const", {HI, LO}, 64'h00000005_00000006);
        run_md("div_zero", 3'd3, 32'hFFFFFF00, 32'd0);

        // Back-to-back moves with no idle cycle between them.
        run_mt("mthi", 3'd5, 32'h1234);
        run_mt("mtlo", 3'd6, 32'h5678);
        chk("mt_const", {HI, LO}, 64'h00001234_00005678);

        // NONE and reserved opcodes leave everything alone.
        start_op(3'd0, 32'hDEAD, 32'hBEEF);
        chk("none_busy", {63'b0, busy}, 64'd0);
        chk("none_hilo", {HI, LO}, {m_hi, m_lo});
        start_op(3'd7, 32'hDEAD, 32'hBEEF);
        chk("rsv_busy", {63'b0, busy}, 64'd0);
        chk("rsv_hilo", {HI, LO}, {m_hi, m_lo});

        // Request during RUN is dropped; only the first MULT's result lands.
        issue(3'd1, 32'hFFFFFFF0, 32'd7);
        @(posedge clk); #1;
        start_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("ignore", int'(MC), 2);

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'(1 + (i % 4));
            a  = $urandom;
            b  = (i == 6) ? 32'd0 : $urandom;
            if (i == 5) b = 32'hFFFFFFFF;
            run_md($sformatf("rnd%0d", i), op, a, b);
        end

        // Asynchronous reset in the middle of a divide.
        run_mt("pre_rst", 3'd5, 32'hAAAA5555);
        issue(3'd3, 32'd100, 32'd7);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_hilo", {HI, LO}, 64'd0);
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(posedge clk); #1;
        chk("arst_hold", {HI, LO, 63'b0, busy} != 0 ? 64'd1 : 64'd0, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        run_md("post_rst", 3'd2, 32'd12345, 32'd678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no-finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
